mmio_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller that sits between the CPU core's data port and data memory. It decodes the data address and routes each access to one of two places: FPGA I/O (switches, buttons, LEDs, seven-segment nibbles) or the data memory. Compared with the fixed hard-wired address map, it adds:
- two-flop input synchronisers,
- optional button debouncing,
- sticky clear-on-read button-press flags,
- readback of output registers,
- suppression of memory accesses that hit mapped I/O.

---
 rtl/mmio_if.sv | 26 ++
 rtl/mmio_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mmio_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_if.sv
// mmio_if: core data-port bus between the CPU core, the MMIO controller and
// data memory. The master modport is the core/memory side, the slave modport
// is the controller side.
interface mmio_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
);
  logic                 rdEn;
  logic                 wrEn;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wrData;
  logic [DATA_SIZE-1:0] rdDataMem;
  logic [DATA_SIZE-1:0] rdData;
  logic                 memRdEn;
  logic                 memWrEn;

  modport master (
    output rdEn, wrEn, addr, wrData, rdDataMem,
    input  rdData, memRdEn, memWrEn
  );

  modport slave (
    input  rdEn, wrEn, addr, wrData, rdDataMem,
    output rdData, memRdEn, memWrEn
  );
endinterface

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: decodes the core data address and routes each access either to
// FPGA I/O (switches, buttons, LEDs, seven-segment nibbles) or to data memory.
// Inputs are two-flop synchronised; button rising edges set sticky
// clear-on-read press flags. Reads have one cycle of latency for both targets.
// Optional feature macro: IO_DEBOUNCE_EN (button debounce counters).
module mmio_ctrl #(
  parameter int                   ADDR_SIZE  = 8,
  parameter int                   DATA_SIZE  = 8,
  parameter int                   SW_WIDTH   = 8,
  parameter int                   NUM_BTN    = 4,
  parameter int                   NUM_LD     = 8,
  parameter int                   NUM_SSD    = 4,
  parameter logic [ADDR_SIZE-1:0] IN_BASE    = 8'he0,
  parameter logic [ADDR_SIZE-1:0] LD_BASE    = 8'hf0,
  parameter logic [ADDR_SIZE-1:0] SSD_BASE   = 8'hfa,
  parameter int                   DEB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_if.slave                bus,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [NUM_BTN-1:0]   btn,
  output logic [NUM_LD-1:0]    ld,
  output logic [4*NUM_SSD-1:0] ssd,
  output logic [NUM_BTN-1:0]   btnPress
);
  // Input window: switches, then button levels, then press flags.
  localparam logic [ADDR_SIZE-1:0] IN_LEN  = ADDR_SIZE'(1 + 2 * NUM_BTN);
  localparam logic [ADDR_SIZE-1:0] LD_LEN  = ADDR_SIZE'(NUM_LD);
  localparam logic [ADDR_SIZE-1:0] SSD_LEN = ADDR_SIZE'(NUM_SSD);

  logic [SW_WIDTH-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [NUM_BTN-1:0]   btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [NUM_BTN-1:0]   btn_lvl;
  logic [NUM_BTN-1:0]   prev_q, prev_d;
  logic [NUM_BTN-1:0]   press_q, press_d;
  logic [NUM_LD-1:0]    ld_q, ld_d;
  logic [4*NUM_SSD-1:0] ssd_q, ssd_d;
  logic                 sel_mem_q, sel_mem_d;
  logic [DATA_SIZE-1:0] io_rd_q, io_rd_d;

  logic [ADDR_SIZE-1:0] in_off, ld_off, ssd_off;
  logic                 in_hit, ld_hit, ssd_hit, mapped;
  logic [DATA_SIZE-1:0] io_val;

  // Only wrData[3:0] carries information for the I/O registers.
  logic unused_wr_bits;
  assign unused_wr_bits = ^bus.wrData;

  // Address decode: offset from each window base plus an in-range test.
  always_comb begin
    in_off  = bus.addr - IN_BASE;
    ld_off  = bus.addr - LD_BASE;
    ssd_off = bus.addr - SSD_BASE;
    in_hit  = (bus.addr >= IN_BASE)  && (in_off  < IN_LEN);
    ld_hit  = (bus.addr >= LD_BASE)  && (ld_off  < LD_LEN);
    ssd_hit = (bus.addr >= SSD_BASE) && (ssd_off < SSD_LEN);
    mapped  = in_hit || ld_hit || ssd_hit;
  end

  assign bus.memRdEn = bus.rdEn & ~mapped;
  assign bus.memWrEn = bus.wrEn & ~mapped;

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [NUM_BTN-1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_BTN-1:0]            deb_lvl_q, deb_lvl_d;

  // Debounce: count consecutive cycles where the input disagrees with the level.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    deb_lvl_d = deb_lvl_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_s2_q[i] == deb_lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
        deb_lvl_d[i] = ~deb_lvl_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_cnt_q <= '0;
      deb_lvl_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_lvl_q <= deb_lvl_d;
    end
  end

  assign btn_lvl = deb_lvl_q;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign btn_lvl = btn_s2_q;
`endif

  // Value an I/O read would return for the current address.
  always_comb begin
    io_val = '0;
    if (in_hit) begin
      if (in_off == '0) io_val = DATA_SIZE'(sw_s2_q);
      for (int i = 0; i < NUM_BTN; i++) begin
        if (in_off == ADDR_SIZE'(1 + i))           io_val = DATA_SIZE'(btn_lvl[i]);
        if (in_off == ADDR_SIZE'(1 + NUM_BTN + i)) io_val = DATA_SIZE'(press_q[i]);
      end
    end else if (ld_hit) begin
      for (int i = 0; i < NUM_LD; i++)
        if (ld_off == ADDR_SIZE'(i)) io_val = DATA_SIZE'(ld_q[i]);
    end else if (ssd_hit) begin
      for (int j = 0; j < NUM_SSD; j++)
        if (ssd_off == ADDR_SIZE'(j)) io_val = DATA_SIZE'(ssd_q[4*j +: 4]);
    end
  end

  // Next state: synchronisers, output registers, press flags, read path.
  always_comb begin
    sw_s1_d   = sw;
    sw_s2_d   = sw_s1_q;
    btn_s1_d  = btn;
    btn_s2_d  = btn_s1_q;
    ld_d      = ld_q;
    ssd_d     = ssd_q;
    prev_d    = btn_lvl;
    press_d   = press_q;
    sel_mem_d = sel_mem_q;
    io_rd_d   = io_rd_q;

    if (bus.wrEn && ld_hit) begin
      for (int i = 0; i < NUM_LD; i++)
        if (ld_off == ADDR_SIZE'(i)) ld_d[i] = bus.wrData[0];
    end
    if (bus.wrEn && ssd_hit) begin
      for (int j = 0; j < NUM_SSD; j++)
        if (ssd_off == ADDR_SIZE'(j)) ssd_d[4*j +: 4] = bus.wrData[3:0];
    end

    // A rising edge wins over a clear-on-read in the same cycle.
    for (int i = 0; i < NUM_BTN; i++) begin
      if (bus.rdEn && in_hit && (in_off == ADDR_SIZE'(1 + NUM_BTN + i)))
        press_d[i] = 1'b0;
      if (btn_lvl[i] && !prev_q[i])
        press_d[i] = 1'b1;
    end

    if (bus.rdEn) begin
      sel_mem_d = ~mapped;
      if (mapped) io_rd_d = io_val;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      ld_q      <= '0;
      ssd_q     <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      sel_mem_q <= 1'b0;
      io_rd_q   <= '0;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      ld_q      <= ld_d;
      ssd_q     <= ssd_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      sel_mem_q <= sel_mem_d;
      io_rd_q   <= io_rd_d;
    end
  end

  assign bus.rdData = sel_mem_q ? bus.rdDataMem : io_rd_q;
  assign ld         = ld_q;
  assign ssd        = ssd_q;
  assign btnPress   = press_q;
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb_mmio_ctrl: directed stimulus with a behavioural reference model of the
// address map, input conditioning and read path, compared every cycle,
// plus hand-computed literal expectations.
module tb_mmio_ctrl;
  localparam int NB  = 4;
  localparam int NL  = 8;
  localparam int NS  = 4;
  localparam int DEB = 16;
`ifdef IO_DEBOUNCE_EN
  localparam bit DEB_ON   = 1'b1;
  localparam int EDGE_LAT = 2 + DEB;
`else
  localparam bit DEB_ON   = 1'b0;
  localparam int EDGE_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    sw = '0;
  logic [NB-1:0] btn = '0;
  logic [NL-1:0] ld;
  logic [15:0]   ssd;
  logic [NB-1:0] btnPress;

  mmio_if #(.ADDR_SIZE(8), .DATA_SIZE(8)) bus ();

  mmio_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sw(sw), .btn(btn),
    .ld(ld), .ssd(ssd), .btnPress(btnPress)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit [7:0]  m_ld, m_sw1, m_sw2, m_io;
  bit [15:0] m_ssd;
  bit [3:0]  m_flag, m_prev, m_b1, m_b2, m_deb;
  int        m_streak [NB];
  bit        m_sel;
  bit [3:0]  lvl_now;
  int        a;

  function automatic bit in_win(int x);  return x >= 'he0 && x < 'he0 + 1 + 2*NB; endfunction
  function automatic bit ld_win(int x);  return x >= 'hf0 && x < 'hf0 + NL;       endfunction
  function automatic bit ssd_win(int x); return x >= 'hfa && x < 'hfa + NS;       endfunction
  function automatic bit is_mapped(int x); return in_win(x) || ld_win(x) || ssd_win(x); endfunction

  function automatic bit [3:0] level();
    return DEB_ON ? m_deb : m_b2;
  endfunction

  function automatic bit [7:0] io_value(int x);
    bit [3:0] l = level();
    if (x == 'he0)                    return m_sw2;
    if (x >= 'he1 && x < 'he1 + NB)   return {7'd0, l[x - 'he1]};
    if (in_win(x))                    return {7'd0, m_flag[x - 'he1 - NB]};
    if (ld_win(x))                    return {7'd0, m_ld[x - 'hf0]};
    if (ssd_win(x))                   return {4'd0, m_ssd[4*(x - 'hfa) +: 4]};
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_ld = '0; m_ssd = '0; m_flag = '0; m_prev = '0; m_b1 = '0; m_b2 = '0;
      m_deb = '0; m_sw1 = '0; m_sw2 = '0; m_io = '0; m_sel = 1'b0;
      for (int i = 0; i < NB; i++) m_streak[i] = 0;
    end else begin
      a = int'(bus.addr);
      if (bus.rdEn) begin
        m_sel = !is_mapped(a);
        if (!m_sel) m_io = io_value(a);
      end
      if (bus.wrEn && ld_win(a))  m_ld[a - 'hf0] = bus.wrData[0];
      if (bus.wrEn && ssd_win(a)) m_ssd[4*(a - 'hfa) +: 4] = bus.wrData[3:0];
      lvl_now = level();
      for (int i = 0; i < NB; i++) begin
        if (lvl_now[i] && !m_prev[i])                m_flag[i] = 1'b1;
        else if (bus.rdEn && a == 'he1 + NB + i)     m_flag[i] = 1'b0;
      end
      m_prev = lvl_now;
      for (int i = 0; i < NB; i++) begin
        if (m_b2[i] != m_deb[i]) m_streak[i]++;
        else m_streak[i] = 0;
        if (m_streak[i] == DEB) begin
          m_deb[i] = ~m_deb[i];
          m_streak[i] = 0;
        end
      end
      m_sw2 = m_sw1; m_sw1 = sw;
      m_b2 = m_b1;   m_b1 = btn;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rdData",   bus.rdData, m_sel ? bus.rdDataMem : m_io);
      chk("cyc_memRdEn",  bus.memRdEn, bus.rdEn && !is_mapped(int'(bus.addr)));
      chk("cyc_memWrEn",  bus.memWrEn, bus.wrEn && !is_mapped(int'(bus.addr)));
      chk("cyc_ld",       ld, m_ld);
      chk("cyc_ssd",      ssd, m_ssd);
      chk("cyc_btnPress", btnPress, m_flag);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rdEn = 0; bus.wrEn = 0; bus.addr = '0; bus.wrData = '0; bus.rdDataMem = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    at_neg();
    chk("rst_ld", ld, 8'h00);
    chk("rst_ssd", ssd, 16'h0000);
    chk("rst_btnPress", btnPress, 4'h0);
    chk("rst_rdData", bus.rdData, 8'h00);
    reset = 1'b1;

    // LED and SSD writes
    bus.wrEn = 1; bus.addr = 8'hf3; bus.wrData = 8'h01;
    at_neg(); chk("wr_led_memWrEn", bus.memWrEn, 1'b0);
    cyc();
    bus.addr = 8'hfc; bus.wrData = 8'h07;
    at_neg(); chk("wr_ssd_memWrEn", bus.memWrEn, 1'b0);
    cyc();
    bus.wrEn = 0;
    at_neg();
    chk("ld_after_wr", ld, 8'h08);
    chk("ssd_nib2", ssd[11:8], 4'h7);
    bus.rdEn = 1; bus.addr = 8'hfc;
    cyc();
    bus.rdEn = 0;
    at_neg(); chk("rd_ssd2", bus.rdData, 8'h07);

    // Write and read of the same LED in one cycle returns the old value
    bus.rdEn = 1; bus.wrEn = 1; bus.addr = 8'hf0; bus.wrData = 8'h01;
    cyc();
    bus.rdEn = 0; bus.wrEn = 0;
    at_neg();
    chk("rd_during_wr_old", bus.rdData, 8'h00);
    chk("ld_after_wr0", ld, 8'h09);

    // Switches through the synchroniser
    sw = 8'hA5;
    repeat (3) cyc();
    bus.rdEn = 1; bus.addr = 8'he0;
    at_neg(); chk("rd_sw_memRdEn", bus.memRdEn, 1'b0);
    cyc();
    bus.rdEn = 0;
    at_neg(); chk("rd_sw", bus.rdData, 8'hA5);

    // Memory read
    bus.rdEn = 1; bus.addr = 8'h10; bus.rdDataMem = 8'h3C;
    at_neg(); chk("rd_mem_memRdEn", bus.memRdEn, 1'b1);
    cyc();
    bus.rdEn = 0;
    at_neg(); chk("rd_mem", bus.rdData, 8'h3C);

    // Unmapped write reaches memory
    bus.wrEn = 1; bus.addr = 8'h20; bus.wrData = 8'h55;
    at_neg(); chk("wr_mem_memWrEn", bus.memWrEn, 1'b1);
    cyc();
    bus.wrEn = 0;

    // Button 2 press and clear-on-read
    btn[2] = 1'b1;
    repeat (DEB + 4) cyc();
    btn[2] = 1'b0;
    repeat (DEB + 4) cyc();
    at_neg(); chk("btn2_flag_set", btnPress[2], 1'b1);
    bus.rdEn = 1; bus.addr = 8'he7;
    cyc();
    bus.rdEn = 0;
    at_neg(); chk("rd_flag2_first", bus.rdData, 8'h01);
    bus.rdEn = 1;
    cyc();
    bus.rdEn = 0;
    at_neg();
    chk("rd_flag2_second", bus.rdData, 8'h00);
    chk("btn2_flag_clr", btnPress[2], 1'b0);

    // Set/clear collision on button 1
    btn[1] = 1'b1;
    repeat (EDGE_LAT + 2) cyc();
    btn[1] = 1'b0;
    repeat (EDGE_LAT + 2) cyc();
    at_neg(); chk("btn1_flag_set", btnPress[1], 1'b1);
    btn[1] = 1'b1;
    repeat (EDGE_LAT) cyc();
    bus.rdEn = 1; bus.addr = 8'he6;
    cyc();
    bus.rdEn = 0;
    at_neg();
    chk("collide_rd", bus.rdData, 8'h01);
    chk("collide_set_wins", btnPress[1], 1'b1);
    bus.rdEn = 1;
    cyc();
    bus.rdEn = 0;
    at_neg(); chk("btn1_flag_clr", btnPress[1], 1'b0);
    btn[1] = 1'b0;
    repeat (EDGE_LAT + 2) cyc();

    // Three-cycle glitch on button 0
    btn[0] = 1'b1;
    repeat (3) cyc();
`ifdef IO_DEBOUNCE_EN
    btn[0] = 1'b0;
    repeat (DEB + 6) cyc();
    at_neg(); chk("glitch_filtered", btnPress[0], 1'b0);
`else
    at_neg(); chk("glitch_flag", btnPress[0], 1'b1);
    btn[0] = 1'b0;
    repeat (4) cyc();
`endif

    // Write to the input window is dropped
    bus.wrEn = 1; bus.addr = 8'he0; bus.wrData = 8'hFF;
    at_neg(); chk("wr_in_memWrEn", bus.memWrEn, 1'b0);
    cyc();
    bus.wrEn = 0;
    at_neg();
    chk("wr_in_ld", ld, 8'h09);
    chk("wr_in_ssd", ssd, 16'h0700);

    // Reset during a pending memory read discards it
    bus.rdEn = 1; bus.addr = 8'h10; bus.rdDataMem = 8'h3C;
    reset = 1'b0;
    cyc();
    bus.rdEn = 0; reset = 1'b1;
    at_neg();
    chk("rst_mid_rdData", bus.rdData, 8'h00);
    chk("rst_mid_ld", ld, 8'h00);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
